// File: rtl/ac_ir_pkg.sv
// Shared definitions for the AC IR remote: settings encodings, frame constants,
// scheduler states and the two-segment payload packer.
package ac_ir_pkg;

  typedef enum logic [2:0] {
    MODE_AUTO = 3'd0,
    MODE_COOL = 3'd1,
    MODE_DRY  = 3'd2,
    MODE_FAN  = 3'd3,
    MODE_HEAT = 3'd4
  } mode_e;

  localparam int unsigned TEMP_MIN   = 16;
  localparam int unsigned TEMP_MAX   = 30;
  localparam int unsigned TEMP_RESET = 26;
  localparam logic [3:0]  TCODE_MAX   = 4'(TEMP_MAX - TEMP_MIN);
  localparam logic [3:0]  TCODE_RESET = 4'(TEMP_RESET - TEMP_MIN);

  localparam logic [22:0] HDR_A      = 23'h2A0C05;
  localparam logic [27:0] HDR_B      = 28'h0004000;
  localparam logic [3:0]  CHK_OFFSET = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_A,
    ST_WAIT_A,
    ST_GAP,
    ST_SEND_B,
    ST_WAIT_B
  } state_e;

  typedef struct packed {
    logic [34:0] data35;
    logic [31:0] data32;
  } payload_t;

  function automatic payload_t pack_payload(input logic [3:0] tcode,
                                            input logic [2:0] mode,
                                            input logic [1:0] fan,
                                            input logic       power);
    payload_t   p;
    logic [3:0] chk;
    chk      = tcode + {1'b0, mode} + {2'b00, fan} + CHK_OFFSET;
    p.data35 = {HDR_A, tcode, 2'b00, fan, power, mode};
    p.data32 = {HDR_B, chk};
    return p;
  endfunction

endpackage

// File: rtl/ac_ir_cmd_scheduler_key_debounce.sv
// One front-panel key: 2-FF synchronizer, stable-level debounce counter and a
// single-cycle pulse on each accepted rising edge.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 800000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // Any return to the accepted level restarts the count, so bounce never accumulates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt    <= '0;
        stable <= sync2;
        press  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ac_ir_cmd_scheduler.sv
// AC IR command scheduler: debounced keys update the settings and each accepted
// command sequences the encoder through segment A, a gap, then segment B.
module ac_ir_cmd_scheduler
  import ac_ir_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 800000,
  parameter int unsigned GAP_CYCLES      = 800000,
  parameter int unsigned TIMEOUT_CYCLES  = 4000000,
  parameter int unsigned LED_CYCLES      = 4000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_power,
  input  logic        key_mode,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_fan,
  output logic        tx_start,
  output logic        tx_seg,
  output logic [34:0] tx_data35,
  output logic [31:0] tx_data32,
  input  logic        tx_done,
  output logic        busy,
  output logic        led_out,
  output logic        err
);

  localparam int unsigned TMAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned LW   = $clog2(LED_CYCLES + 1);

  logic p_power, p_mode, p_up, p_down, p_fan;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_power (.clk(clk), .rst(rst), .key(key_power), .press(p_power));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode  (.clk(clk), .rst(rst), .key(key_mode),  .press(p_mode));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up    (.clk(clk), .rst(rst), .key(key_up),    .press(p_up));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down  (.clk(clk), .rst(rst), .key(key_down),  .press(p_down));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fan   (.clk(clk), .rst(rst), .key(key_fan),   .press(p_fan));

  logic          power, power_n;
  logic [2:0]    mode, mode_n;
  logic [3:0]    tcode, tcode_n;
  logic [1:0]    fan, fan_n;
  logic          cmd;

  state_e        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          pending;
  logic          pending_clr;
  logic          snap_load;
  logic          err_set;
  logic [LW-1:0] led_cnt;
  payload_t      snap;

  // A power pulse wins the cycle; with power off every other key is dropped.
  always_comb begin
    power_n = power;
    mode_n  = mode;
    tcode_n = tcode;
    fan_n   = fan;
    cmd     = 1'b0;
    if (p_power) begin
      power_n = ~power;
      cmd     = 1'b1;
    end else if (power && (p_mode || p_up || p_down || p_fan)) begin
      cmd = 1'b1;
      if (p_mode)
        mode_n = (mode == 3'(MODE_HEAT)) ? 3'(MODE_AUTO) : mode + 3'd1;
      if (p_up && !p_down && (tcode != TCODE_MAX))
        tcode_n = tcode + 4'd1;
      if (p_down && !p_up && (tcode != '0))
        tcode_n = tcode - 4'd1;
      if (p_fan)
        fan_n = fan + 2'd1;
    end
  end

  always_comb begin
    state_n     = state;
    timer_n     = '0;
    snap_load   = 1'b0;
    pending_clr = 1'b0;
    err_set     = 1'b0;
    tx_start    = (state == ST_SEND_A) || (state == ST_SEND_B);
    tx_seg      = (state == ST_SEND_B) || (state == ST_WAIT_B);
    busy        = (state != ST_IDLE);
    led_out     = (led_cnt != '0);
    unique case (state)
      ST_IDLE: begin
        if (cmd || pending) begin
          state_n     = ST_SEND_A;
          snap_load   = 1'b1;
          pending_clr = 1'b1;
        end
      end
      ST_SEND_A: state_n = ST_WAIT_A;
      ST_WAIT_A: begin
        if (tx_done) begin
          state_n = ST_GAP;
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          state_n     = ST_IDLE;
          err_set     = 1'b1;
          pending_clr = 1'b1;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      ST_GAP: begin
        if (timer == TW'(GAP_CYCLES - 1))
          state_n = ST_SEND_B;
        else
          timer_n = timer + 1'b1;
      end
      ST_SEND_B: state_n = ST_WAIT_B;
      ST_WAIT_B: begin
        // Back-to-back frame skips IDLE so tx_start lands the cycle after tx_done.
        if (tx_done) begin
          if (cmd || pending) begin
            state_n     = ST_SEND_A;
            snap_load   = 1'b1;
            pending_clr = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          state_n     = ST_IDLE;
          err_set     = 1'b1;
          pending_clr = 1'b1;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      timer   <= '0;
      pending <= 1'b0;
      err     <= 1'b0;
      led_cnt <= '0;
      power   <= 1'b0;
      mode    <= 3'(MODE_AUTO);
      tcode   <= TCODE_RESET;
      fan     <= '0;
      snap    <= pack_payload(TCODE_RESET, 3'(MODE_AUTO), 2'b00, 1'b0);
    end else begin
      state <= state_n;
      timer <= timer_n;
      power <= power_n;
      mode  <= mode_n;
      tcode <= tcode_n;
      fan   <= fan_n;
      if (snap_load)
        snap <= pack_payload(tcode_n, mode_n, fan_n, power_n);
      if (pending_clr)
        pending <= 1'b0;
      else if (cmd && (state != ST_IDLE))
        pending <= 1'b1;
      if (err_set)
        err <= 1'b1;
      if (cmd)
        led_cnt <= LW'(LED_CYCLES);
      else if (led_cnt != '0)
        led_cnt <= led_cnt - 1'b1;
    end
  end

  assign tx_data35 = snap.data35;
  assign tx_data32 = snap.data32;

endmodule

// File: tb/tb_ac_ir_cmd_scheduler.sv
// Scoreboard bench for ac_ir_cmd_scheduler: directed key presses push expected
// frames; a monitor pops and compares on every tx_start and tx_done.
module tb_ac_ir_cmd_scheduler;

  localparam int K_POWER = 0;
  localparam int K_MODE  = 1;
  localparam int K_UP    = 2;
  localparam int K_DOWN  = 3;
  localparam int K_FAN   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  keys = '0;
  logic        tx_done = 1'b0;
  logic        tx_start, tx_seg, busy, led_out, err;
  logic [34:0] tx_data35;
  logic [31:0] tx_data32;
  logic        enc_en = 1'b1;

  always #5 clk = ~clk;

  ac_ir_cmd_scheduler #(
    .DEBOUNCE_CYCLES(4),
    .GAP_CYCLES(8),
    .TIMEOUT_CYCLES(50),
    .LED_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst),
    .key_power(keys[K_POWER]), .key_mode(keys[K_MODE]), .key_up(keys[K_UP]),
    .key_down(keys[K_DOWN]), .key_fan(keys[K_FAN]),
    .tx_start(tx_start), .tx_seg(tx_seg), .tx_data35(tx_data35), .tx_data32(tx_data32),
    .tx_done(tx_done), .busy(busy), .led_out(led_out), .err(err)
  );

  typedef struct {
    logic        seg;
    logic [34:0] d35;
    logic [31:0] d32;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [3:0] tc, input logic [1:0] fan, input logic pw,
                            input logic [2:0] mode, input logic [3:0] chk, input logic with_b);
    exp_t e;
    e.seg = 1'b0;
    e.d35 = {23'h2A0C05, tc, 2'b00, fan, pw, mode};
    e.d32 = {28'h0004000, chk};
    sb.push_back(e);
    if (with_b) begin
      e.seg = 1'b1;
      sb.push_back(e);
    end
  endtask

  // Encoder model: answers tx_done 30 cycles after each tx_start.
  always begin
    @(negedge clk);
    if (tx_start && enc_en && !rst) begin
      repeat (30) @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t cur;
  logic have_cur = 1'b0;
  int   done_cyc = 0;
  int   start_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      have_cur = 1'b0;
    end else begin
      if (tx_start) begin
        start_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx_start: got seg %0d data35 %0h expected no frame", tx_seg, tx_data35);
        end else begin
          cur      = sb.pop_front();
          have_cur = 1'b1;
          check("start_seg", 64'(tx_seg), 64'(cur.seg));
          check("start_data35", 64'(tx_data35), 64'(cur.d35));
          check("start_data32", 64'(tx_data32), 64'(cur.d32));
          if (cur.seg)
            check("gap_len", 64'(cyc - done_cyc), 64'd9);
        end
      end
      if (tx_done && have_cur) begin
        check("done_data35_held", 64'(tx_data35), 64'(cur.d35));
        check("done_data32_held", 64'(tx_data32), 64'(cur.d32));
        done_cyc = cyc;
        have_cur = 1'b0;
      end
    end
  end

  int   led_run = 0;
  int   led_last = 0;
  int   led_rises = 0;
  logic led_q = 1'b0;

  always @(negedge clk) begin
    if (led_out) led_run++;
    if (led_out && !led_q) led_rises++;
    if (!led_out && led_q) led_last = led_run;
    if (!led_out) led_run = 0;
    led_q = led_out;
  end

  task automatic press(input int k);
    @(posedge clk);
    #1 keys[k] = 1'b1;
    repeat (8) @(posedge clk);
    #1 keys[k] = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tx_start"}, 64'(tx_start), 64'd0);
    check({tag, "_tx_seg"}, 64'(tx_seg), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_led"}, 64'(led_out), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_data35"}, 64'(tx_data35), 64'h2A0C05A00);
    check({tag, "_data32"}, 64'(tx_data32), 64'h0004000F);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises0;
    int starts0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("reset");

    // Power off: non-power keys are ignored entirely.
    rises0  = led_rises;
    starts0 = start_cnt;
    press(K_MODE);
    press(K_FAN);
    press(K_UP);
    repeat (20) @(negedge clk);
    check("poweroff_led_rises", 64'(led_rises), 64'(rises0));
    check("poweroff_starts", 64'(start_cnt), 64'(starts0));
    check("poweroff_data35", 64'(tx_data35), 64'h2A0C05A00);

    // Power on: tcode 10, power 1, chk F; single command lights LED for 20 cycles.
    push_frame(4'd10, 2'd0, 1'b1, 3'd0, 4'hF, 1'b1);
    press(K_POWER);
    wait_idle("idle_after_power_on");
    repeat (5) @(negedge clk);
    check("led_len", 64'(led_last), 64'd20);
    check("err_after_power_on", 64'(err), 64'd0);

    // Five up presses: first frame tcode 11 (chk 0), rest coalesce into tcode 14 (chk 3).
    push_frame(4'd11, 2'd0, 1'b1, 3'd0, 4'h0, 1'b1);
    push_frame(4'd14, 2'd0, 1'b1, 3'd0, 4'h3, 1'b1);
    for (int i = 0; i < 5; i++) press(K_UP);
    wait_idle("idle_after_up_burst");
    check("sb_empty_after_burst", 64'(sb.size()), 64'd0);

    // Saturated up still retransmits.
    push_frame(4'd14, 2'd0, 1'b1, 3'd0, 4'h3, 1'b1);
    press(K_UP);
    wait_idle("idle_after_saturated_up");

    // Mode press during WAIT_A: in-flight frame unchanged, one follow-up with mode 1 (chk 4).
    push_frame(4'd14, 2'd0, 1'b1, 3'd0, 4'h3, 1'b1);
    push_frame(4'd14, 2'd0, 1'b1, 3'd1, 4'h4, 1'b1);
    press(K_UP);
    press(K_MODE);
    wait_idle("idle_after_mid_frame");
    check("sb_empty_after_mid_frame", 64'(sb.size()), 64'd0);

    // Timeout: encoder silent; fan 1 frame (chk 5), segment B never sent.
    enc_en = 1'b0;
    push_frame(4'd14, 2'd1, 1'b1, 3'd1, 4'h5, 1'b0);
    press(K_FAN);
    wait_idle("idle_after_timeout");
    check("timeout_err", 64'(err), 64'd1);
    repeat (20) @(negedge clk);
    check("timeout_err_sticky", 64'(err), 64'd1);
    check("timeout_busy", 64'(busy), 64'd0);
    enc_en = 1'b1;

    // Reset in GAP: outputs back to reset values, no segment B follows.
    push_frame(4'd14, 2'd1, 1'b1, 3'd1, 4'h5, 1'b0);
    press(K_UP);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (tx_done) break;
    end
    check("wait_tx_done_a", 64'(tx_done), 64'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset("rst_in_gap");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    starts0 = start_cnt;
    repeat (60) @(negedge clk);
    check("no_start_after_reset", 64'(start_cnt), 64'(starts0));
    check("busy_after_reset", 64'(busy), 64'd0);
    check("sb_empty_final", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
